// File: rtl/motor_cmd_tx.sv
// motor_cmd_tx: frames a pair of 8-bit motor commands as SYNC/one/two and
// sends them as UART 8N1 on TxD. The last accepted pair is re-sent after a
// quiet period so the far end's motor-kill timeout stays disarmed.
module motor_cmd_tx #(
    parameter int ClkFrequency = 100000000,
    parameter int Baud         = 115200,
    parameter int KeepAlive    = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_one,
    input  logic [7:0] cmd_two,
    output logic       TxD,
    output logic       busy,
    output logic       frame_done
);

    // Bit period in clocks; must be at least 2 for the counter to make sense.
    localparam int DIV = ClkFrequency / Baud;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [31:0] KA_LAST = 32'(KeepAlive - 1);
    localparam logic [7:0]  SYNC    = 8'hFF;
    localparam logic [7:0]  STOPCMD = 8'd127;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic          frame_done_q, frame_done_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    one_q, two_q;
    logic          has_cmd;
    logic [31:0]   ka_cnt;
    logic          txd_q;
    logic [7:0]    cur_byte;
    logic          bit_end, accept, ka_fire, frame_start;

    // A payload byte of 0xFF would look like SYNC on the wire, so nudge it down.
    function automatic logic [7:0] sanitize(input logic [7:0] b);
        return (b == 8'hFF) ? 8'hFE : b;
    endfunction

    assign bit_end     = (baud_cnt == CW'(DIV - 1));
    assign accept      = cmd_valid && (state == IDLE);
    assign ka_fire     = (state == IDLE) && has_cmd && (ka_cnt == KA_LAST) && !cmd_valid;
    assign frame_start = accept || ka_fire;

    // Next-state logic: walks start/data/stop for each of the three bytes.
    always_comb begin
        state_next      = state;
        frame_done_next = 1'b0;
        case (state)
            IDLE:  if (frame_start) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
            STOP: begin
                if (bit_end) begin
                    if (byte_idx == 2'd2) begin
                        state_next      = IDLE;
                        frame_done_next = 1'b1;
                    end else begin
                        state_next = START;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and the end-of-frame pulse, aligned with the return to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            frame_done_q <= frame_done_next;
        end
    end

    // Bit-period, bit and byte counters; all parked at zero while idle.
    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
            if (state == DATA && bit_end)
                bit_idx <= bit_idx + 3'd1;
            if (state == STOP && bit_end && byte_idx != 2'd2)
                byte_idx <= byte_idx + 2'd1;
        end
    end

    // Command latch: inputs are only looked at on the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            one_q   <= STOPCMD;
            two_q   <= STOPCMD;
            has_cmd <= 1'b0;
        end else if (accept) begin
            one_q   <= sanitize(cmd_one);
            two_q   <= sanitize(cmd_two);
            has_cmd <= 1'b1;
        end
    end

    // Keepalive timer: counts idle cycles once a command exists, saturating at expiry.
    always_ff @(posedge clk) begin
        if (!rst_n || state != IDLE || frame_start || !has_cmd)
            ka_cnt <= '0;
        else if (ka_cnt != KA_LAST)
            ka_cnt <= ka_cnt + 32'd1;
    end

    // Byte currently on the wire: SYNC first, then the two payload bytes.
    always_comb begin
        cur_byte = SYNC;
        case (byte_idx)
            2'd1:    cur_byte = one_q;
            2'd2:    cur_byte = two_q;
            default: cur_byte = SYNC;
        endcase
    end

    // Registered line driver; lags the state by one cycle so TxD is glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txd_q <= 1'b1;
        end else begin
            case (state)
                START:   txd_q <= 1'b0;
                DATA:    txd_q <= cur_byte[bit_idx];
                default: txd_q <= 1'b1;
            endcase
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign TxD        = txd_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_motor_cmd_tx.sv
// tb_motor_cmd_tx: directed sequence with random payloads, checking the
// serial waveform against a frame model built from the UART 8N1 framing rules.
module tb_motor_cmd_tx;

    localparam int CLK_HZ = 1600;
    localparam int BAUD   = 100;
    localparam int KA     = 2000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FRAME  = 30 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_one;
    logic [7:0] cmd_two;
    logic       TxD;
    logic       busy;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] last_one, last_two;
    logic [7:0] ra, rb;

    motor_cmd_tx #(
        .ClkFrequency(CLK_HZ),
        .Baud(BAUD),
        .KeepAlive(KA)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_one(cmd_one),
        .cmd_two(cmd_two),
        .TxD(TxD),
        .busy(busy),
        .frame_done(frame_done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [7:0] san(input logic [7:0] b);
        return (b == 8'hFF) ? 8'hFE : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = v;
        cmd_one   = a;
        cmd_two   = b;
    endtask

    // n idle cycles: line high, ready, not busy, no frame_done.
    task automatic idleWindow(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (TxD !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || frame_done !== 1'b0)
                bad++;
        end
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    // Called just after the frame-starting edge k; ends just after edge k+FRAME.
    task automatic frameCheck(input logic [7:0] e1, input logic [7:0] e2, input bit hold, input string tag);
        logic [7:0] exp_bytes [3];
        logic       wave [FRAME];
        logic [7:0] dec;
        logic       expb;
        int bad_txd, bad_ctl, bitpos, bidx, w;
        exp_bytes[0] = 8'hFF;
        exp_bytes[1] = e1;
        exp_bytes[2] = e2;
        bad_txd = 0;
        bad_ctl = 0;
        checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
        checkOutput({tag, "_ready_start"}, 32'(cmd_ready), 32'd0);
        checkOutput({tag, "_txd_latency"}, 32'(TxD), 32'd1);
        for (int i = 1; i <= FRAME; i++) begin
            if (hold) begin
                cmd_one = 8'($urandom);
                cmd_two = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            bitpos = (i - 1) / DIV;
            bidx   = bitpos / 10;
            w      = bitpos % 10;
            if (w == 0)      expb = 1'b0;
            else if (w == 9) expb = 1'b1;
            else             expb = exp_bytes[bidx][w-1];
            wave[i-1] = TxD;
            if (TxD !== expb) bad_txd++;
            if (i < FRAME && (busy !== 1'b1 || cmd_ready !== 1'b0 || frame_done !== 1'b0))
                bad_ctl++;
        end
        checkOutput({tag, "_txd_wave"}, 32'(bad_txd), 32'd0);
        checkOutput({tag, "_ctl_in_frame"}, 32'(bad_ctl), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd1);
        checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
        checkOutput({tag, "_ready_end"}, 32'(cmd_ready), 32'd1);
        for (int b = 0; b < 3; b++) begin
            dec = 8'h00;
            for (int j = 0; j < 8; j++)
                dec[j] = wave[(b * 10 + 1 + j) * DIV + DIV / 2];
            checkOutput($sformatf("%s_byte%0d", tag, b), 32'(dec), 32'(exp_bytes[b]));
        end
    endtask

    // Accept a command on the next edge and check the resulting frame.
    task automatic sendCmd(input logic [7:0] a, input logic [7:0] b, input bit hold, input string tag);
        applyStimulus(1'b1, a, b);
        tick();
        last_one = san(a);
        last_two = san(b);
        frameCheck(last_one, last_two, hold, tag);
    endtask

    // Quiet period followed by a keepalive resend of the last command.
    task automatic keepaliveFrame(input string tag);
        idleWindow(KA - 1, {tag, "_quiet"});
        tick();
        frameCheck(last_one, last_two, 1'b0, tag);
    endtask

    // Directed sequence.
    initial begin
        applyStimulus(1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        repeat (3) tick();
        checkOutput("reset_txd", 32'(TxD), 32'd1);
        checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        idleWindow(5000, "no_cmd_idle");

        sendCmd(8'h40, 8'hC8, 1'b0, "f1");
        sendCmd(8'hFF, 8'h7F, 1'b1, "f2_held");
        ra = 8'($urandom);
        rb = 8'($urandom);
        sendCmd(ra, rb, 1'b0, "f3_after_hold");
        for (int r = 0; r < 3; r++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (r == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            sendCmd(ra, rb, 1'b0, $sformatf("rand%0d", r));
        end

        keepaliveFrame("ka1");
        keepaliveFrame("ka2");

        idleWindow(KA - 1, "pre_expiry");
        ra = 8'($urandom);
        rb = 8'($urandom);
        sendCmd(ra, rb, 1'b0, "expiry_cmd");
        idleWindow(KA - 1, "post_expiry");
        tick();
        checkOutput("ka3_busy_start", 32'(busy), 32'd1);
        repeat (200) tick();
        rst_n = 1'b0;
        tick();
        checkOutput("midreset_txd", 32'(TxD), 32'd1);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_ready", 32'(cmd_ready), 32'd1);
        checkOutput("midreset_done", 32'(frame_done), 32'd0);
        checkOutput("midreset_one", 32'(dut.one_q), 32'd127);
        checkOutput("midreset_two", 32'(dut.two_q), 32'd127);
        rst_n = 1'b1;
        idleWindow(5000, "post_reset_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
